// File: rtl/fetch_unit_if.sv
// Fetch-stage bus bundle: instruction-memory req/ack and the fetch-to-decode
// valid/ready channel. The fetch unit is the master; memory/decode sit on the slave side.
interface fetch_unit_if;
  logic        imemReq;
  logic [31:0] imemAddr;
  logic        imemAck;
  logic [31:0] imemRdata;
  logic        instrValid;
  logic        instrReady;
  logic [31:0] instruction;
  logic [31:0] pc;
  logic [31:0] pcPlus4;
  logic        pcSrc;
  logic [31:0] immediateExtended;

  modport master (
    output imemReq, imemAddr, instrValid, instruction, pc, pcPlus4,
    input  imemAck, imemRdata, instrReady, pcSrc, immediateExtended
  );

  modport slave (
    input  imemReq, imemAddr, instrValid, instruction, pc, pcPlus4,
    output imemAck, imemRdata, instrReady, pcSrc, immediateExtended
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, fetches one word at a time, hands it to decode.
// Optional macro FETCH_MISALIGN_TRAP_EN adds a sticky misaligned-branch trap and halt state.
module fetch_unit #(
  parameter logic [31:0] RESET_PC       = 32'h0000_0000,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic              i_clk,
  input  logic              i_rst,
  fetch_unit_if.master      bus,
  output logic              o_fetchTimeout,
`ifdef FETCH_MISALIGN_TRAP_EN
  output logic              o_misaligned,
`endif
  output logic [1:0]        o_dbgState
);

  // Handshakes: imemReq is held with a stable imemAddr until a cycle with imemAck,
  // whose imemRdata is captured that cycle. instrValid holds instruction/pc stable
  // until a cycle with instrValid & instrReady, which is the single accept event.
  localparam logic [31:0] NOP_INSTR   = 32'h0000_0013;
  localparam logic [15:0] TIMEOUT_LIM = 16'(TIMEOUT_CYCLES);

`ifdef FETCH_MISALIGN_TRAP_EN
  typedef enum logic [1:0] {S_BOOT = 2'd0, S_REQ = 2'd1, S_HOLD = 2'd2, S_HALT = 2'd3} state_e;
`else
  typedef enum logic [1:0] {S_BOOT = 2'd0, S_REQ = 2'd1, S_HOLD = 2'd2} state_e;
`endif

  state_e      state_q;
  logic [31:0] pc_q;
  logic [31:0] instr_q;
  logic        req_q;
  logic        valid_q;
  logic        timeout_q;
  logic [15:0] wdog_q;
  logic [31:0] target_d;
  logic [31:0] next_pc_d;
`ifdef FETCH_MISALIGN_TRAP_EN
  logic        misaligned_q;
`endif

  assign target_d  = pc_q + bus.immediateExtended;
  assign next_pc_d = bus.pcSrc ? target_d : (pc_q + 32'd4);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q      <= S_BOOT;
      pc_q         <= RESET_PC;
      instr_q      <= NOP_INSTR;
      req_q        <= 1'b0;
      valid_q      <= 1'b0;
      timeout_q    <= 1'b0;
      wdog_q       <= 16'd0;
`ifdef FETCH_MISALIGN_TRAP_EN
      misaligned_q <= 1'b0;
`endif
    end else begin
      case (state_q)
        S_BOOT: begin
          state_q <= S_REQ;
          req_q   <= 1'b1;
        end
        S_REQ: begin
          if (bus.imemAck) begin
            instr_q <= bus.imemRdata;
            wdog_q  <= 16'd0;
            req_q   <= 1'b0;
            valid_q <= 1'b1;
            state_q <= S_HOLD;
          end else if (wdog_q < TIMEOUT_LIM) begin
            // Counter saturates at the limit; the request stays up so a late ack still lands.
            wdog_q <= wdog_q + 16'd1;
            if (wdog_q == TIMEOUT_LIM - 16'd1) timeout_q <= 1'b1;
          end
        end
        S_HOLD: begin
          if (bus.instrReady) begin
`ifdef FETCH_MISALIGN_TRAP_EN
            if (bus.pcSrc && (target_d[1:0] != 2'b00)) begin
              misaligned_q <= 1'b1;
              valid_q      <= 1'b0;
              state_q      <= S_HALT;
            end else begin
              pc_q    <= next_pc_d;
              valid_q <= 1'b0;
              req_q   <= 1'b1;
              state_q <= S_REQ;
            end
`else
            pc_q    <= next_pc_d;
            valid_q <= 1'b0;
            req_q   <= 1'b1;
            state_q <= S_REQ;
`endif
          end
        end
`ifdef FETCH_MISALIGN_TRAP_EN
        S_HALT: begin
          state_q <= S_HALT;
        end
`endif
        default: begin
          state_q <= S_BOOT;
        end
      endcase
    end
  end

  assign bus.imemReq     = req_q;
  assign bus.imemAddr    = pc_q;
  assign bus.instrValid  = valid_q;
  assign bus.instruction = instr_q;
  assign bus.pc          = pc_q;
  assign bus.pcPlus4     = pc_q + 32'd4;
  assign o_fetchTimeout  = timeout_q;
  assign o_dbgState      = state_q;
`ifdef FETCH_MISALIGN_TRAP_EN
  assign o_misaligned    = misaligned_q;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: reset, fetch/accept latency, stalls, branches,
// watchdog, reset during a pending request and the misaligned-branch path.
module tb_fetch_unit;

  logic       clk;
  logic       rst;
  logic       fetch_timeout;
  logic [1:0] dbg_state;
`ifdef FETCH_MISALIGN_TRAP_EN
  logic       misaligned;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  fetch_unit_if bus ();

  fetch_unit #(
    .RESET_PC       (32'h0000_0000),
    .TIMEOUT_CYCLES (4)
  ) dut (
    .i_clk          (clk),
    .i_rst          (rst),
    .bus            (bus.master),
    .o_fetchTimeout (fetch_timeout),
`ifdef FETCH_MISALIGN_TRAP_EN
    .o_misaligned   (misaligned),
`endif
    .o_dbgState     (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Inputs change and outputs are sampled at the falling edge.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic ack_with(input string tag, input logic [31:0] data);
    check_eq({tag, "_req_before_ack"}, {31'd0, bus.imemReq}, 32'd1);
    bus.imemAck   = 1'b1;
    bus.imemRdata = data;
    step();
    bus.imemAck   = 1'b0;
    bus.imemRdata = 32'h0;
    check_eq({tag, "_valid"}, {31'd0, bus.instrValid}, 32'd1);
    check_eq({tag, "_instr"}, bus.instruction, data);
    check_eq({tag, "_req_low"}, {31'd0, bus.imemReq}, 32'd0);
  endtask

  task automatic accept(input logic src, input logic [31:0] imm);
    bus.instrReady        = 1'b1;
    bus.pcSrc             = src;
    bus.immediateExtended = imm;
    step();
    bus.instrReady        = 1'b0;
    bus.pcSrc             = 1'b0;
    bus.immediateExtended = 32'h0;
  endtask

  initial begin
    rst                   = 1'b1;
    bus.imemAck           = 1'b0;
    bus.imemRdata         = 32'h0;
    bus.instrReady        = 1'b0;
    bus.pcSrc             = 1'b0;
    bus.immediateExtended = 32'h0;
    @(negedge clk);
    repeat (3) step();

    check_eq("rst_req",     {31'd0, bus.imemReq},    32'd0);
    check_eq("rst_valid",   {31'd0, bus.instrValid}, 32'd0);
    check_eq("rst_instr",   bus.instruction,         32'h0000_0013);
    check_eq("rst_pc",      bus.pc,                  32'h0);
    check_eq("rst_timeout", {31'd0, fetch_timeout},  32'd0);
    check_eq("rst_state",   {30'd0, dbg_state},      32'd0);

    // Boot cycle, then request at address 0; ack arrives on the second request cycle.
    rst = 1'b0;
    step();
    check_eq("boot_req",  {31'd0, bus.imemReq}, 32'd1);
    check_eq("boot_addr", bus.imemAddr,         32'h0);
    step();
    check_eq("req_held",  {31'd0, bus.imemReq}, 32'd1);
    check_eq("req_addr",  bus.imemAddr,         32'h0);
    ack_with("f0", 32'h0050_0093);
    check_eq("f0_pc",     bus.pc,      32'h0);
    check_eq("f0_pcp4",   bus.pcPlus4, 32'h4);

    // Stall: outputs held, branch inputs and stray acks ignored while not accepting.
    bus.pcSrc             = 1'b1;
    bus.immediateExtended = 32'h55;
    for (int i = 0; i < 5; i++) begin
      bus.imemAck   = (i == 2);
      bus.imemRdata = 32'hDEAD_BEEF;
      step();
      check_eq("stall_valid", {31'd0, bus.instrValid}, 32'd1);
      check_eq("stall_instr", bus.instruction,         32'h0050_0093);
      check_eq("stall_pc",    bus.pc,                  32'h0);
    end
    bus.imemAck   = 1'b0;
    bus.imemRdata = 32'h0;

    accept(1'b0, 32'h0);
    check_eq("seq_valid_drop", {31'd0, bus.instrValid}, 32'd0);
    check_eq("seq_req",        {31'd0, bus.imemReq},    32'd1);
    check_eq("seq_addr",       bus.imemAddr,            32'h4);

    ack_with("f1", 32'h1111_1111);
    check_eq("f1_pcp4", bus.pcPlus4, 32'h8);
    accept(1'b1, 32'h0000_00FC);
    check_eq("br_fwd_addr", bus.imemAddr, 32'h100);

    ack_with("f2", 32'h2222_2222);
    accept(1'b1, 32'hFFFF_FFF0);
    check_eq("br_back_addr", bus.imemAddr, 32'hF0);

    // Watchdog: limit 4, flag visible after the fourth unacked request cycle.
    check_eq("wd_c1", {31'd0, fetch_timeout}, 32'd0);
    repeat (3) step();
    check_eq("wd_c4", {31'd0, fetch_timeout}, 32'd0);
    step();
    check_eq("wd_set",  {31'd0, fetch_timeout}, 32'd1);
    check_eq("wd_req",  {31'd0, bus.imemReq},   32'd1);
    check_eq("wd_addr", bus.imemAddr,           32'hF0);
    repeat (3) step();
    ack_with("late", 32'h3333_3333);
    check_eq("wd_sticky", {31'd0, fetch_timeout}, 32'd1);
    accept(1'b0, 32'h0);
    check_eq("wd_next_addr", bus.imemAddr, 32'hF4);

    // Reset while a request is pending, with an ack on the reset cycle.
    rst           = 1'b1;
    bus.imemAck   = 1'b1;
    bus.imemRdata = 32'h4444_4444;
    step();
    rst           = 1'b0;
    bus.imemAck   = 1'b0;
    bus.imemRdata = 32'h0;
    check_eq("rr_pc",      bus.pc,                  32'h0);
    check_eq("rr_req",     {31'd0, bus.imemReq},    32'd0);
    check_eq("rr_valid",   {31'd0, bus.instrValid}, 32'd0);
    check_eq("rr_instr",   bus.instruction,         32'h0000_0013);
    check_eq("rr_timeout", {31'd0, fetch_timeout},  32'd0);
    check_eq("rr_state",   {30'd0, dbg_state},      32'd0);
    step();
    check_eq("rr_new_req",  {31'd0, bus.imemReq},    32'd1);
    check_eq("rr_new_addr", bus.imemAddr,            32'h0);
    step();
    check_eq("rr_no_valid", {31'd0, bus.instrValid}, 32'd0);

    // Reach pc=0x10, then branch by +6 (misaligned target).
    ack_with("f3", 32'h5555_5555);
    accept(1'b1, 32'h0000_0010);
    check_eq("to10_addr", bus.imemAddr, 32'h10);
    ack_with("f4", 32'h6666_6666);
    accept(1'b1, 32'h0000_0006);
`ifdef FETCH_MISALIGN_TRAP_EN
    check_eq("mis_flag",  {31'd0, misaligned},      32'd1);
    check_eq("mis_pc",    bus.pc,                   32'h10);
    check_eq("mis_req",   {31'd0, bus.imemReq},     32'd0);
    check_eq("mis_valid", {31'd0, bus.instrValid},  32'd0);
    repeat (3) step();
    check_eq("halt_req",   {31'd0, bus.imemReq},    32'd0);
    check_eq("halt_valid", {31'd0, bus.instrValid}, 32'd0);
    check_eq("halt_state", {30'd0, dbg_state},      32'd3);
`else
    check_eq("odd_pc",   bus.pc,               32'h16);
    check_eq("odd_req",  {31'd0, bus.imemReq}, 32'd1);
    check_eq("odd_addr", bus.imemAddr,         32'h16);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
